// File: rtl/mul_ctrl.sv
// Sequencer around an external unsigned 32x32->64 multiplier for MULT/MULTU/MTHI/MTLO.
// A multiply keeps busy high for LATENCY+1 cycles; MTHI/MTLO complete in one cycle with no busy.
// While busy, start is ignored and stall = start | mf_req; decode must hold and re-present.
module mul_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        mf_req,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  // The counter needs at least one bit even when LATENCY is 1.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_WB   = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sign, sign_nxt;
  logic [31:0]   mul_a_nxt, mul_b_nxt;
  logic [31:0]   hi_nxt, lo_nxt;
  logic          done_nxt;
  logic [63:0]   prod;

  // Magnitude of a two's-complement word; 0x80000000 stays 0x80000000,
  // which is the correct magnitude once read as unsigned.
  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Next-state and next-register values; everything holds unless the state says otherwise.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sign_nxt  = sign;
    mul_a_nxt = mul_a;
    mul_b_nxt = mul_b;
    hi_nxt    = hi;
    lo_nxt    = lo;
    done_nxt  = 1'b0;
    prod      = sign ? (~mul_z + 64'd1) : mul_z;

    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULTU: begin
              mul_a_nxt = rs;
              mul_b_nxt = rt;
              sign_nxt  = 1'b0;
              cnt_nxt   = CNT_LOAD;
              state_nxt = S_CALC;
            end
            OP_MULT: begin
              mul_a_nxt = mag(rs);
              mul_b_nxt = mag(rt);
              sign_nxt  = rs[31] ^ rt[31];
              cnt_nxt   = CNT_LOAD;
              state_nxt = S_CALC;
            end
            OP_MTHI: hi_nxt = rs;
            OP_MTLO: lo_nxt = rs;
            default: ;
          endcase
        end
      end
      // Operands stay frozen here so the multiplier sees a stable multicycle path.
      S_CALC: begin
        if (cnt == '0) state_nxt = S_WB;
        else           cnt_nxt   = cnt - CW'(1);
      end
      // mul_z has settled; apply the sign and retire to HI/LO.
      S_WB: begin
        hi_nxt    = prod[63:32];
        lo_nxt    = prod[31:0];
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state register: FSM, latency counter, sign and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      sign  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sign  <= sign_nxt;
      done  <= done_nxt;
    end
  end

  // Datapath registers: multiplier operands and the HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a <= '0;
      mul_b <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      mul_a <= mul_a_nxt;
      mul_b <= mul_b_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  assign busy  = (state != S_IDLE);
  assign stall = busy & (start | mf_req);

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed and random checks of mul_ctrl against a signed/unsigned arithmetic reference.
module tb_mul_ctrl;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset, start, mf_req;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic [63:0] mul_z;
  logic        busy, stall, done;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  mul_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .mf_req(mf_req), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  // Multiplier model: plain unsigned product.
  assign mul_z = {32'd0, mul_a} * {32'd0, mul_b};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of MULT/MULTU.
  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] ua, ub;
    if (o == 2'b01) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return 64'(sp);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Issues a multiply at the current negedge and returns in its done cycle.
  // If icyc >= 0, a random start/mf_req is presented in busy cycle icyc.
  task automatic run_mult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int icyc);
    logic [63:0] p;
    logic [31:0] ma, mb;
    p = ref_prod(o, a, b);
    ma = '0;
    mb = '0;
    start = 1'b1; op = o; rs = a; rt = b; mf_req = 1'b0;
    #1;
    check("issue_busy", 64'(busy), 64'd0);
    check("issue_stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      if (i == icyc) begin
        start = 1'b1; op = 2'($urandom_range(0, 3)); rs = $urandom; rt = $urandom; mf_req = 1'b1;
        #1;
        check("busy_stall", 64'(stall), 64'd1);
      end
      check("busy_hi", 64'(busy), 64'd1);
      check("busy_done", 64'(done), 64'd0);
      check("hold_hilo", {hi, lo}, {m_hi, m_lo});
      if (i == 0) begin
        ma = mul_a;
        mb = mul_b;
        check("operand_prod", mul_z, ref_prod(2'b00, mul_a, mul_b));
      end else begin
        check("hold_ops", {mul_a, mul_b}, {ma, mb});
      end
      @(negedge clk);
      start = 1'b0;
      mf_req = 1'b0;
    end
    m_hi = p[63:32];
    m_lo = p[31:0];
    check("wb_busy", 64'(busy), 64'd0);
    check("wb_done", 64'(done), 64'd1);
    check("wb_hilo", {hi, lo}, {m_hi, m_lo});
    check("wb_ops_kept", {mul_a, mul_b}, {ma, mb});
  endtask

  // One-cycle MTHI/MTLO; result visible at the next negedge.
  task automatic run_mt(input logic [1:0] o, input logic [31:0] v);
    start = 1'b1; op = o; rs = v; rt = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (o == 2'b10) m_hi = v; else m_lo = v;
    check("mt_hilo", {hi, lo}, {m_hi, m_lo});
    check("mt_busy", 64'(busy), 64'd0);
    check("mt_done", 64'(done), 64'd0);
  endtask

  task automatic idle_check;
    @(negedge clk);
    check("idle_done", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mf_req = 1'b0; op = 2'b00; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_ops", {mul_a, mul_b}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    mf_req = 1'b1; start = 1'b1; #1;
    check("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; mf_req = 1'b0;
    @(negedge clk);

    // Directed arithmetic corners.
    run_mult(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    idle_check();
    run_mult(2'b01, 32'hFFFFFFFD, 32'd7, -1);
    check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    idle_check();
    run_mult(2'b01, 32'h80000000, 32'h80000000, -1);
    check("mult_minmin", {hi, lo}, 64'h40000000_00000000);
    idle_check();

    // MTHI then MTLO on consecutive cycles.
    run_mt(2'b10, 32'h12345678);
    run_mt(2'b11, 32'h9ABCDEF0);
    check("mt_pair", {hi, lo}, 64'h12345678_9ABCDEF0);
    idle_check();

    // Start and mf_req during CALC are stalled and ignored.
    run_mult(2'b00, 32'd1000, 32'd77, 1);
    check("interfere_res", {hi, lo}, 64'd77000);
    idle_check();

    // Reset in the second CALC cycle aborts without a done pulse.
    start = 1'b1; op = 2'b01; rs = 32'hFFFFFF00; rt = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_ops", {mul_a, mul_b}, 64'd0);
    for (int i = 0; i < LAT + 4; i++) begin
      check("abort_nodone", 64'(done), 64'd0);
      @(negedge clk);
    end

    // Back-to-back: second op issued in the first op's done cycle.
    run_mult(2'b00, 32'd2, 32'd3, -1);
    check("b2b_first", {hi, lo}, 64'd6);
    run_mult(2'b01, 32'hFFFFFFFF, 32'd5, -1);
    check("b2b_second", {hi, lo}, 64'hFFFFFFFF_FFFFFFFB);
    idle_check();

    // Random mix of operations with random interference while busy.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] o;
      o = 2'($urandom_range(0, 3));
      if (o[1]) run_mt(o, $urandom);
      else begin
        run_mult(o, $urandom, $urandom, $urandom_range(0, LAT + 2) - 1);
        if ($urandom_range(0, 1) == 1) idle_check();
      end
    end
    idle_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
